// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : E-stage multiply/divide unit that owns HI/LO. Optional macro
//            MDU_DIV0_EN makes divide-by-zero write LO=all-ones, HI=dividend.
// Revision : 1.0
// ============================================================================
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        En,
  input  logic        Start,
  input  logic [2:0]  Select,
  input  logic [1:0]  MFSelect,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [2:0] c_sel_mthi = 3'b100;
  localparam logic [2:0] c_sel_mtlo = 3'b101;

  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [63:0]        res_q, res_d;
  logic               wr_q, wr_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  logic        accept, start_op, is_div, div_zero;
  logic [31:0] divisor;
  logic [63:0] mul_s, mul_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign Busy     = (cnt_q != '0);
  assign accept   = En & ~Req & ~Busy;
  assign start_op = Start & ~Select[2];
  assign is_div   = Select[1];
  assign div_zero = (B == 32'd0);

  // Substitute 1 for a zero divisor so the arithmetic never sees X; the result is discarded or overridden.
  assign divisor = div_zero ? 32'd1 : B;
  assign mul_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign mul_u   = {32'd0, A} * {32'd0, B};
  assign quo_s   = $signed(A) / $signed(divisor);
  assign rem_s   = $signed(A) % $signed(divisor);
  assign quo_u   = A / divisor;
  assign rem_u   = A % divisor;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    res_d = res_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (Busy) begin
      cnt_d = cnt_q - c_cnt_w'(1);
      if (cnt_q == c_cnt_w'(1) && wr_q) begin
        {hi_d, lo_d} = res_q;
      end
    end else if (accept) begin
      if (start_op) begin
        cnt_d = is_div ? c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
        wr_d  = 1'b1;
        case (Select[1:0])
          2'b00:   res_d = mul_s;
          2'b01:   res_d = mul_u;
          2'b10:   res_d = {rem_s, quo_s};
          default: res_d = {rem_u, quo_u};
        endcase
        if (is_div && div_zero) begin
`ifdef MDU_DIV0_EN
          res_d = {A, 32'hFFFF_FFFF};
`else
          wr_d  = 1'b0;
`endif
        end
      end else if (Select == c_sel_mthi) begin
        hi_d = A;
      end else if (Select == c_sel_mtlo) begin
        lo_d = A;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      res_q <= 64'd0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      res_q <= res_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    Out = 32'd0;
    case (MFSelect)
      2'b00:   Out = hi_q;
      2'b01:   Out = lo_q;
      default: Out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// Scoreboard bench for mdu_unit: stimulus queues expected HI/LO reads and
// Busy run lengths; one negedge monitor pops and compares them.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        En = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Select = 3'b111;
  logic [1:0]  MFSelect = 2'b10;
  logic        Req = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] Out;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .En(En), .Start(Start), .Select(Select),
    .MFSelect(MFSelect), .Req(Req), .A(A), .B(B), .Busy(Busy), .Out(Out)
  );

  typedef struct packed {
    logic        busy;
    logic [31:0] out;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    run_q[$];
  int    total = 0;
  int    bad = 0;
  logic  chk = 1'b0;
  int    run = 0;

  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    int    exp_n;
    if (chk) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_mon: read observed with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (Busy !== e.busy || Out !== e.out) begin
          bad++;
          $display("FAIL %s: got busy=%0b out=%08h, want busy=%0b out=%08h",
                   nm, Busy, Out, e.busy, e.out);
        end
      end
    end
    if (Busy === 1'b1) begin
      run++;
    end else if (run > 0) begin
      total++;
      if (run_q.size() == 0) begin
        bad++;
        $display("FAIL busy_run: unexpected busy run of %0d cycles, want none", run);
      end else begin
        exp_n = run_q.pop_front();
        if (run != exp_n) begin
          bad++;
          $display("FAIL busy_run: got %0d busy cycles, want %0d", run, exp_n);
        end
      end
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic req = 1'b0);
    En = 1'b1; Start = st; Select = sel; A = a; B = b; Req = req;
    step();
    En = 1'b0; Start = 1'b0; Select = 3'b111; Req = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF;
  endtask

  task automatic check(input string nm, input logic [1:0] mf,
                       input logic bsy, input logic [31:0] val);
    MFSelect = mf;
    exp_q.push_back(exp_t'({bsy, val}));
    name_q.push_back(nm);
    chk = 1'b1;
    step();
    chk = 1'b0;
    MFSelect = 2'b10;
  endtask

  task automatic check_hl(input string nm, input logic [31:0] hi, input logic [31:0] lo);
    check({nm, "_hi"}, 2'b00, 1'b0, hi);
    check({nm, "_lo"}, 2'b01, 1'b0, lo);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", nm, Busy, n);
    end
  endtask

  initial begin
    step();
    step();
    check_hl("reset", 32'd0, 32'd0);
    reset_n = 1'b1;
    step();

    run_q.push_back(MULT_N);
    issue(1'b1, 3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_busy_old_lo", 2'b01, 1'b1, 32'd0);
    wait_idle("mult");
    check_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_q.push_back(MULT_N);
    issue(1'b1, 3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_idle("multu");
    check_hl("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    check("mf_none", 2'b10, 1'b0, 32'd0);

    run_q.push_back(MULT_N);
    issue(1'b1, 3'b000, 32'h8000_0000, 32'h8000_0000);
    wait_idle("mult_minmin");
    check_hl("mult_minmin", 32'h4000_0000, 32'h0000_0000);

    run_q.push_back(DIV_N);
    issue(1'b1, 3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_idle("div");
    check_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_q.push_back(DIV_N);
    issue(1'b1, 3'b010, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_idle("div_negdiv");
    check_hl("div_negdiv", 32'h0000_0001, 32'hFFFF_FFFD);

    run_q.push_back(DIV_N);
    issue(1'b1, 3'b011, 32'h0000_0007, 32'h0000_0002);
    wait_idle("divu");
    check_hl("divu", 32'h0000_0001, 32'h0000_0003);

    run_q.push_back(DIV_N);
    issue(1'b1, 3'b011, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_idle("divu_big");
    check_hl("divu_big", 32'h0000_000F, 32'h0FFF_FFFF);

    issue(1'b0, 3'b100, 32'h1234_5678, 32'd0);
    check("mthi", 2'b00, 1'b0, 32'h1234_5678);
    issue(1'b1, 3'b101, 32'hCAFE_BABE, 32'd0);
    check_hl("mtlo_start", 32'h1234_5678, 32'hCAFE_BABE);
    issue(1'b1, 3'b111, 32'h1111_1111, 32'h2222_2222);
    check_hl("sel_none", 32'h1234_5678, 32'hCAFE_BABE);

    issue(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(1'b0, 3'b100, 32'h3333_3333, 32'd0, 1'b1);
    check_hl("req_block", 32'h1234_5678, 32'hCAFE_BABE);

    run_q.push_back(MULT_N);
    issue(1'b1, 3'b000, 32'h0000_0003, 32'h0000_0004);
    issue(1'b1, 3'b011, 32'h0000_0100, 32'h0000_0003);
    issue(1'b0, 3'b101, 32'h0000_DEAD, 32'd0);
    issue(1'b0, 3'b100, 32'h0000_BEEF, 32'd0);
    wait_idle("busy_ignore");
    check_hl("busy_ignore", 32'h0000_0000, 32'h0000_000C);

    run_q.push_back(DIV_N);
    issue(1'b1, 3'b010, 32'h0000_0005, 32'h0000_0000);
    wait_idle("div0");
`ifdef MDU_DIV0_EN
    check_hl("div0", 32'h0000_0005, 32'hFFFF_FFFF);
`else
    check_hl("div0", 32'h0000_0000, 32'h0000_000C);
`endif

    run_q.push_back(3);
    issue(1'b1, 3'b011, 32'h0000_0064, 32'h0000_0007);
    repeat (3) step();
    reset_n = 1'b0;
    check_hl("rst_mid", 32'd0, 32'd0);
    reset_n = 1'b1;
    repeat (15) step();
    check_hl("post_rst", 32'd0, 32'd0);

    total++;
    if (exp_q.size() != 0 || run_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d reads and %0d busy runs pending, want 0 and 0",
               exp_q.size(), run_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
